// File: rtl/ser_pkg.sv
// ser_pkg: shared FSM state type and default frame parameters for serial_tx
package ser_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV   = 4;
endpackage

// File: rtl/ser_baud_tick.sv
// ser_baud_tick: bit-period counter; counts 0..DIV-1 and pulses TICK on the last count
// Ports: CLK clock, RST async active-high reset, CLR hold count at 0, TICK high while count==DIV-1
module ser_baud_tick import ser_pkg::*; #(
    parameter int DIV = DEF_DIV
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign TICK = cnt_q == CW'(DIV - 1);
    always_comb cnt_d = (CLR || TICK) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: start/data(LSB first)/stop serializer with DIV clocks per bit
// Ports: CLK clock, RST async active-high reset, DIN word to send, LOAD send request
//        (sampled only while READY), READY can accept a word, TXD serial line (idle 1),
//        BUSY registered complement of READY
module serial_tx import ser_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    output logic             READY,
    output logic             TXD,
    output logic             BUSY
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             tick, txd_d, txd_q, rdy_q, busy_q;
    // Holding the counter clear in IDLE makes it start from 0 on entry to START.
    ser_baud_tick #(.DIV(DIV)) u_baud (
        .CLK (CLK),
        .RST (RST),
        .CLR (state_q == IDLE),
        .TICK(tick)
    );
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE:  if (LOAD) begin
                       sh_d    = DIN;
                       idx_d   = '0;
                       state_d = START;
                   end
            START: if (tick) state_d = DATA;
            DATA:  if (tick) begin
                       sh_d  = sh_q >> 1;
                       idx_d = (idx_q == IW'(WIDTH - 1)) ? '0 : idx_q + IW'(1);
                       state_d = (idx_q == IW'(WIDTH - 1)) ? STOP : DATA;
                   end
            STOP:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are computed from next state so the flops present them in the same edge.
        txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            rdy_q   <= state_d == IDLE;
            busy_q  <= state_d != IDLE;
        end
    end
    assign TXD   = txd_q;
    assign READY = rdy_q;
    assign BUSY  = busy_q;
endmodule
